gmii_rx_guard: RTL and testbench

//   GMII receive-side guard; sits between the PCS/PMA GMII Rx outputs and the Rx input of the GTX MAC wrapper.

---
 rtl/gmii_rx_guard_pkg.sv | 24 ++
 rtl/gmii_rx_guard_if.sv | 18 +
 rtl/gmii_rx_guard_sat_counter.sv | 29 ++
 rtl/gmii_rx_guard.sv | 156 +++++++++++++++
 tb/tb_gmii_rx_guard.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_rx_guard_pkg.sv
// Shared encodings and helpers for the GMII receive guard.
package gmii_rx_guard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FRAME   = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   localparam logic [7:0] FALSE_CARRIER = 8'h0E;
   localparam logic [7:0] XOR_MASK      = 8'hFF;

   // Corrupt a byte so the downstream CRC check can never pass on it.
   function automatic logic [7:0] guard_byte(input logic [7:0] d, input logic inv);
      logic [7:0] r;
      if (inv) begin
         r = d ^ XOR_MASK;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/gmii_rx_guard_if.sv
// GMII Rx byte stream in, guarded byte stream out.
interface gmii_rx_guard_if;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic [7:0] out_d;
   logic       out_dv;

   modport master (
      output gmii_rxd, gmii_rx_dv, gmii_rx_er,
      input  out_d, out_dv
   );

   modport slave (
      input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
      output out_d, out_dv
   );
endinterface

// File: rtl/gmii_rx_guard_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a coincident increment.
module gmii_rx_guard_sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] q
);

   logic [CW-1:0] q_r;

   // count register: clear, saturating increment, hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= {CW{1'b0}};
      end else if (clr) begin
         q_r <= {CW{1'b0}};
      end else if (inc && !(&q_r)) begin
         q_r <= q_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/gmii_rx_guard.sv
// GMII Rx guard: corrupts errored bytes, truncates jabber frames, keeps saturating diagnostics.
module gmii_rx_guard
   import gmii_rx_guard_pkg::*;
#(
   parameter int CW       = 16,
   parameter int MAX_LEN  = 16383,
   parameter int RUNT_LEN = 72
) (
   input  logic          clk,
   input  logic          rst_n,
   gmii_rx_guard_if.slave rx,
   input  logic          cnt_clear,
   output logic [CW-1:0] frame_cnt,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] runt_cnt,
   output logic [CW-1:0] over_cnt,
   output logic [CW-1:0] fcar_cnt
);

   localparam logic [31:0] MAX_LEN_U  = 32'(MAX_LEN);
   localparam logic [31:0] RUNT_LEN_U = 32'(RUNT_LEN);

   state_t      state_r, state_s;
   logic [CW:0] len_r, len_s, len_inc_s;
   logic        err_r, err_s, err_acc_s;
   logic [7:0]  out_d_r, out_d_s;
   logic        out_dv_r, out_dv_s;
   logic        idle_ok_r;
   logic        fcar_prev_r, fcar_cond_s;
   logic        fwd_s, hit_max_s;
   logic        inc_frame_s, inc_err_s, inc_runt_s, inc_over_s, inc_fcar_s;

   // FSM, length, error flag and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         len_r       <= {(CW+1){1'b0}};
         err_r       <= 1'b0;
         out_d_r     <= 8'h00;
         out_dv_r    <= 1'b0;
         idle_ok_r   <= 1'b0;
         fcar_prev_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         len_r       <= len_s;
         err_r       <= err_s;
         out_d_r     <= out_d_s;
         out_dv_r    <= out_dv_s;
         idle_ok_r   <= idle_ok_r || !rx.gmii_rx_dv;
         fcar_prev_r <= fcar_cond_s;
      end
   end

   // next state, forwarded byte and counter increments
   always_comb begin
      state_s     = state_r;
      len_s       = len_r;
      err_s       = err_r;
      out_d_s     = 8'h00;
      out_dv_s    = 1'b0;
      fwd_s       = 1'b0;
      inc_frame_s = 1'b0;
      inc_err_s   = 1'b0;
      inc_runt_s  = 1'b0;
      inc_over_s  = 1'b0;

      fcar_cond_s = !rx.gmii_rx_dv && rx.gmii_rx_er && (rx.gmii_rxd == FALSE_CARRIER);
      inc_fcar_s  = fcar_cond_s && !fcar_prev_r;

      if (state_r == ST_FRAME) begin
         len_inc_s = (&len_r) ? len_r : len_r + {{CW{1'b0}}, 1'b1};
         err_acc_s = err_r || rx.gmii_rx_er;
      end else begin
         len_inc_s = {{CW{1'b0}}, 1'b1};
         err_acc_s = rx.gmii_rx_er;
      end
      hit_max_s = (32'(len_inc_s) >= MAX_LEN_U);

      case (state_r)
         ST_IDLE: begin
            // a burst already in flight when reset released is never a frame
            if (rx.gmii_rx_dv && !idle_ok_r) begin
               state_s = ST_DISCARD;
            end else if (rx.gmii_rx_dv) begin
               fwd_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FRAME: begin
            if (rx.gmii_rx_dv) begin
               fwd_s = 1'b1;
            end else begin
               inc_frame_s = 1'b1;
               inc_err_s   = err_r;
               inc_runt_s  = (32'(len_r) < RUNT_LEN_U);
               len_s       = {(CW+1){1'b0}};
               err_s       = 1'b0;
               state_s     = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (rx.gmii_rx_dv) begin
               state_s = ST_DISCARD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            len_s   = {(CW+1){1'b0}};
            err_s   = 1'b0;
         end
      endcase

      if (fwd_s) begin
         out_dv_s = 1'b1;
         out_d_s  = guard_byte(rx.gmii_rxd, rx.gmii_rx_er || hit_max_s);
         // the byte reaching MAX_LEN closes the frame; the rest of the burst is dropped
         if (hit_max_s) begin
            inc_over_s  = 1'b1;
            inc_frame_s = 1'b1;
            inc_err_s   = err_acc_s;
            len_s       = {(CW+1){1'b0}};
            err_s       = 1'b0;
            state_s     = ST_DISCARD;
         end else begin
            len_s   = len_inc_s;
            err_s   = err_acc_s;
            state_s = ST_FRAME;
         end
      end else begin
         out_dv_s = 1'b0;
      end
   end

   assign rx.out_d  = out_d_r;
   assign rx.out_dv = out_dv_r;

   gmii_rx_guard_sat_counter #(.CW(CW)) u_frame_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc_frame_s), .clr(cnt_clear), .q(frame_cnt)
   );
   gmii_rx_guard_sat_counter #(.CW(CW)) u_err_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc_err_s), .clr(cnt_clear), .q(err_cnt)
   );
   gmii_rx_guard_sat_counter #(.CW(CW)) u_runt_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc_runt_s), .clr(cnt_clear), .q(runt_cnt)
   );
   gmii_rx_guard_sat_counter #(.CW(CW)) u_over_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc_over_s), .clr(cnt_clear), .q(over_cnt)
   );
   gmii_rx_guard_sat_counter #(.CW(CW)) u_fcar_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc_fcar_s), .clr(cnt_clear), .q(fcar_cnt)
   );

endmodule

// File: tb/tb_gmii_rx_guard.sv
// Self-checking bench for gmii_rx_guard: directed frames, a vector table and random traffic vs a frame-level model.
module tb_gmii_rx_guard;

   localparam int MAX_LEN  = 100;
   localparam int RUNT_LEN = 72;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cnt_clear = 1'b0;
   logic [7:0] rxd = 8'h00;
   logic       dv = 1'b0;
   logic       er = 1'b0;

   logic [15:0] frame_cnt, err_cnt, runt_cnt, over_cnt, fcar_cnt;
   logic [3:0]  s_frame_cnt, s_err_cnt, s_runt_cnt, s_over_cnt, s_fcar_cnt;

   gmii_rx_guard_if bus_m ();
   gmii_rx_guard_if bus_s ();

   assign bus_m.gmii_rxd   = rxd;
   assign bus_m.gmii_rx_dv = dv;
   assign bus_m.gmii_rx_er = er;
   assign bus_s.gmii_rxd   = rxd;
   assign bus_s.gmii_rx_dv = dv;
   assign bus_s.gmii_rx_er = er;

   gmii_rx_guard #(.CW(16), .MAX_LEN(MAX_LEN), .RUNT_LEN(RUNT_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .rx(bus_m), .cnt_clear(cnt_clear),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt), .runt_cnt(runt_cnt),
      .over_cnt(over_cnt), .fcar_cnt(fcar_cnt)
   );

   // narrow-counter instance, used for saturation
   gmii_rx_guard #(.CW(4), .MAX_LEN(MAX_LEN), .RUNT_LEN(RUNT_LEN)) dut_sat (
      .clk(clk), .rst_n(rst_n), .rx(bus_s), .cnt_clear(cnt_clear),
      .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt), .runt_cnt(s_runt_cnt),
      .over_cnt(s_over_cnt), .fcar_cnt(s_fcar_cnt)
   );

   always #4 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   // frame-level reference model state
   int  m_frame = 0, m_err = 0, m_runt = 0, m_over = 0, m_fcar = 0;
   int  m_pos = 0;
   bit  m_fprev = 1'b0, m_in = 1'b0, m_live = 1'b0, m_synced = 1'b0, m_berr = 1'b0;

   logic       last_dv;
   logic [7:0] last_d;
   int         t_dv_cnt;
   int         t_cap_pos;
   logic [7:0] t_cap;

   typedef struct {
      logic [7:0] d;
      logic       v;
      logic       e;
      logic       xdv;
      logic [7:0] xd;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [7:0] gen_byte(input int k);
      if (k <= 7) return 8'h55;
      if (k == 8) return 8'hD5;
      return 8'((k * 7) + 3);
   endfunction

   task automatic model_clear();
      m_frame = 0; m_err = 0; m_runt = 0; m_over = 0; m_fcar = 0;
   endtask

   // one clock: drive, predict from the frame-level model, compare the output one clock later
   task automatic step(input logic [7:0] d, input logic v, input logic e,
                       input logic r = 1'b1, input logic c = 1'b0);
      logic       exp_dv;
      logic [7:0] exp_d;
      logic       cond;
      @(negedge clk);
      rxd = d; dv = v; er = e; cnt_clear = c;
      exp_dv = 1'b0;
      exp_d  = 8'h00;
      if (!r) begin
         if (rst_n) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_out_dv", 32'(bus_m.out_dv), 32'd0);
         end
         model_clear();
         m_in = 1'b0; m_synced = 1'b0; m_fprev = 1'b0; m_live = 1'b0;
      end else begin
         rst_n = 1'b1;
         cond = !v && e && (d == 8'h0E);
         if (cond && !m_fprev) m_fcar++;
         m_fprev = cond;
         if (v) begin
            if (!m_in) begin
               m_in = 1'b1; m_live = m_synced; m_pos = 0; m_berr = 1'b0;
            end
            if (m_live) begin
               m_pos++;
               exp_dv = 1'b1;
               m_berr = m_berr | e;
               exp_d = (e || m_pos == MAX_LEN) ? (d ^ 8'hFF) : d;
               if (m_pos == MAX_LEN) begin
                  m_frame++; m_over++;
                  if (m_berr) m_err++;
                  m_live = 1'b0;
               end
            end
         end else begin
            if (m_in && m_live) begin
               m_frame++;
               if (m_berr) m_err++;
               if (m_pos < RUNT_LEN) m_runt++;
            end
            m_in = 1'b0;
            m_synced = 1'b1;
         end
         if (c) model_clear();
      end
      @(posedge clk);
      #1;
      chk("out_dv", 32'(bus_m.out_dv), 32'(exp_dv));
      if (exp_dv) chk("out_d", 32'(bus_m.out_d), 32'(exp_d));
      last_dv = bus_m.out_dv;
      last_d  = bus_m.out_d;
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_frame"}, 32'(frame_cnt), 32'(sat(m_frame, 16)));
      chk({tag, "_err"},   32'(err_cnt),   32'(sat(m_err, 16)));
      chk({tag, "_runt"},  32'(runt_cnt),  32'(sat(m_runt, 16)));
      chk({tag, "_over"},  32'(over_cnt),  32'(sat(m_over, 16)));
      chk({tag, "_fcar"},  32'(fcar_cnt),  32'(sat(m_fcar, 16)));
      chk({tag, "_sat_frame"}, 32'(s_frame_cnt), 32'(sat(m_frame, 4)));
      chk({tag, "_sat_fcar"},  32'(s_fcar_cnt),  32'(sat(m_fcar, 4)));
   endtask

   task automatic send_frame(input int len, input int gap, input int epos, input logic [7:0] eval);
      logic [7:0] d;
      t_dv_cnt = 0;
      for (int k = 1; k <= len; k++) begin
         d = (k == epos) ? eval : gen_byte(k);
         step(d, 1'b1, (k == epos));
         t_dv_cnt += int'(last_dv);
         if (k == t_cap_pos) t_cap = last_d;
      end
      for (int g = 0; g < gap; g++) step(8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{8'h0E, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{8'h0E, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[2] = '{8'h0E, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{8'h0F, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[4] = '{8'h0F, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[5] = '{8'h0F, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
      vecs[8] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'hA5};
      vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      t_cap_pos = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_dv", 32'(bus_m.out_dv), 32'd0);
      chk("rst_out_d", 32'(bus_m.out_d), 32'd0);
      check_counters("rst");
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);

      // 1: clean 72-byte frame
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(72, 3, 0, 8'h00);
      chk("t1_dv_cycles", 32'(t_dv_cnt), 32'd72);
      chk("t1_frame", 32'(frame_cnt), 32'd1);
      chk("t1_runt", 32'(runt_cnt), 32'd0);
      check_counters("t1");

      // 2: er on byte 30
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      t_cap_pos = 30;
      send_frame(72, 3, 30, 8'h3C);
      chk("t2_byte30", 32'(t_cap), 32'hC3);
      chk("t2_err", 32'(err_cnt), 32'd1);
      chk("t2_frame", 32'(frame_cnt), 32'd1);

      // 3: 150-byte jabber truncated at MAX_LEN, then a normal frame
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      t_cap_pos = 100;
      send_frame(150, 2, 0, 8'h00);
      chk("t3_dv_cycles", 32'(t_dv_cnt), 32'd100);
      chk("t3_byte100", 32'(t_cap), 32'(gen_byte(100) ^ 8'hFF));
      chk("t3_over", 32'(over_cnt), 32'd1);
      chk("t3_frame", 32'(frame_cnt), 32'd1);
      t_cap_pos = 0;
      send_frame(80, 2, 0, 8'h00);
      chk("t3_next_dv_cycles", 32'(t_dv_cnt), 32'd80);
      chk("t3_frame2", 32'(frame_cnt), 32'd2);
      check_counters("t3");

      // 4: 40-byte runt, 1-cycle gap, 80-byte frame
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(40, 1, 0, 8'h00);
      chk("t4_gap_dv", 32'(last_dv), 32'd0);
      send_frame(80, 2, 0, 8'h00);
      chk("t4_runt", 32'(runt_cnt), 32'd1);
      chk("t4_frame", 32'(frame_cnt), 32'd2);

      // 5: false carrier / carrier extend and a tiny frame, from the vector table
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].d, vecs[i].v, vecs[i].e);
         chk($sformatf("vec%0d_dv", i), 32'(last_dv), 32'(vecs[i].xdv));
         if (vecs[i].xdv) chk($sformatf("vec%0d_d", i), 32'(last_d), 32'(vecs[i].xd));
      end
      chk("t5_fcar", 32'(fcar_cnt), 32'd1);
      chk("t5_frame", 32'(frame_cnt), 32'd1);
      chk("t5_err", 32'(err_cnt), 32'd1);
      chk("t5_runt", 32'(runt_cnt), 32'd1);

      // 6: reset pulse during byte 20 of a 200-byte burst
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      t_dv_cnt = 0;
      for (int k = 1; k <= 200; k++) begin
         step(gen_byte(k), 1'b1, 1'b0, !(k >= 20 && k < 23));
         if (k >= 20) t_dv_cnt += int'(last_dv);
      end
      chk("t6_dv_after_rst", 32'(t_dv_cnt), 32'd0);
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      chk("t6_frame", 32'(frame_cnt), 32'd0);
      chk("t6_over", 32'(over_cnt), 32'd0);
      send_frame(80, 2, 0, 8'h00);
      chk("t6_next_frame", 32'(frame_cnt), 32'd1);

      // clear coincident with the end-of-frame increment
      send_frame(80, 0, 0, 8'h00);
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b0);
      chk("clr_wins_frame", 32'(frame_cnt), 32'd0);
      check_counters("clr");

      // random traffic against the model
      for (int f = 0; f < 300; f++) begin
         int len, gap;
         len = int'($urandom_range(1, 130));
         gap = int'($urandom_range(1, 4));
         for (int k = 0; k < len; k++)
            step(8'($urandom), 1'b1, ($urandom_range(0, 15) == 0));
         for (int g = 0; g < gap; g++) begin
            case ($urandom_range(0, 3))
               0: step(8'h0E, 1'b0, 1'b1);
               1: step(8'h0F, 1'b0, 1'b1);
               2: step(8'($urandom), 1'b0, 1'($urandom));
               default: step(8'h00, 1'b0, 1'b0);
            endcase
         end
         if (f % 50 == 49) check_counters("rand");
      end
      chk("sat_frame_held", 32'(s_frame_cnt), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
